instr_encoder: RTL and testbench

Sequential instruction writer for the single-cycle RISC-V core: accepts a stream of symbolic instruction requests (op class, registers, immediate), encodes each into a 32-bit RV32I word, and writes it into instruction memory at consecutive word addresses. It is the encoding counterpart of the ALU/opcode decode path. It sits between the test/boot host and the instruction memory write port, and holds the core off while a program is being loaded.

---
 rtl/riscv_pkg.sv | 37 +++
 rtl/instr_pack.sv | 49 ++++
 rtl/instr_encoder.sv | 121 ++++++++++++
 tb/tb_instr_encoder.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I encoding constants for the encoder and alu_control paths.
// Op classes, major opcodes, funct fields, loader FSM states, imm helper.
package riscv_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_ADDI = 3'd2;
  localparam logic [2:0] OP_LW   = 3'd3;
  localparam logic [2:0] OP_SW   = 3'd4;
  localparam logic [2:0] OP_BEQ  = 3'd5;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;

  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } ld_state_t;

  // 13-bit value fits a 12-bit signed field iff the top two bits agree.
  function automatic logic fits12(input logic [12:0] imm);
    return imm[12] == imm[11];
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I packer: op class + regs + imm -> 32-bit word.
// In: op, rd, rs1, rs2, imm[12:0]. Out: word, illegal.
module instr_pack
  import riscv_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [12:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    unique case (1'b1)
      (op == OP_ADD): begin
        word = {F7_ADD, rs2, rs1, F3_ADD, rd, OPC_R};
      end
      (op == OP_SUB): begin
        word = {F7_SUB, rs2, rs1, F3_ADD, rd, OPC_R};
      end
      (op == OP_ADDI): begin
        word    = {imm[11:0], rs1, F3_ADD, rd, OPC_I};
        illegal = !fits12(imm);
      end
      (op == OP_LW): begin
        word    = {imm[11:0], rs1, F3_LW, rd, OPC_LOAD};
        illegal = !fits12(imm);
      end
      (op == OP_SW): begin
        word    = {imm[11:5], rs2, rs1, F3_SW,
                   imm[4:0], OPC_STORE};
        illegal = !fits12(imm);
      end
      (op == OP_BEQ): begin
        word    = {imm[12], imm[10:5], rs2, rs1, F3_BEQ,
                   imm[4:1], imm[11], OPC_BRANCH};
        illegal = imm[0];
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: encodes request stream and writes it to imem in order.
// Ports: start/req_* handshake in, imem_* write port, cpu_hold/done/err/count.
module instr_encoder
  import riscv_pkg::*;
#(
  parameter int          IMEM_DEPTH = 256,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [2:0]                    req_op,
  input  logic [4:0]                    req_rd,
  input  logic [4:0]                    req_rs1,
  input  logic [4:0]                    req_rs2,
  input  logic [12:0]                   req_imm,
  input  logic                          req_last,
  output logic                          imem_we,
  output logic [31:0]                   imem_addr,
  output logic [31:0]                   imem_wdata,
  output logic                          cpu_hold,
  output logic                          done,
  output logic                          err,
  output logic [$clog2(IMEM_DEPTH):0]   count
);

  localparam int CW = $clog2(IMEM_DEPTH) + 1;

  ld_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          err_q, err_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          ready_q, hold_q, done_q;
  logic [31:0]   word;
  logic          illegal;

  instr_pack u_pack (
    .op      (req_op),
    .rd      (req_rd),
    .rs1     (req_rs1),
    .rs2     (req_rs2),
    .imm     (req_imm),
    .word    (word),
    .illegal (illegal)
  );

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        if (req_valid) begin
          if (illegal) begin
            err_d = 1'b1;
          end else begin
            we_d    = 1'b1;
            addr_d  = BASE_ADDR + (32'(cnt_q) << 2);
            wdata_d = word;
            cnt_d   = cnt_inc;
          end
          // Stop on last, or when this write fills the memory.
          if (req_last ||
              (!illegal && cnt_inc == CW'(IMEM_DEPTH)))
            state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ready_q <= (state_d == ST_LOAD);
      hold_q  <= (state_d == ST_LOAD);
      done_q  <= (state_d == ST_DONE);
    end
  end

  assign req_ready  = ready_q;
  assign cpu_hold   = hold_q;
  assign done       = done_q;
  assign err        = err_q;
  assign count      = cnt_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: two instances (depth 256 and 4) on one stimulus.
// Behavioural model checked every cycle plus directed literal checks.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        req_valid = 1'b0;
  logic [2:0]  req_op = '0;
  logic [4:0]  req_rd = '0, req_rs1 = '0, req_rs2 = '0;
  logic [12:0] req_imm = '0;
  logic        req_last = 1'b0;

  logic        rdy  [2];
  logic        we   [2];
  logic [31:0] addr [2];
  logic [31:0] wd   [2];
  logic        hold [2];
  logic        dn   [2];
  logic        er   [2];
  logic [8:0]  cnt_a;
  logic [2:0]  cnt_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  instr_encoder #(.IMEM_DEPTH(256)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start),
    .req_valid(req_valid), .req_ready(rdy[0]),
    .req_op(req_op), .req_rd(req_rd), .req_rs1(req_rs1),
    .req_rs2(req_rs2), .req_imm(req_imm), .req_last(req_last),
    .imem_we(we[0]), .imem_addr(addr[0]), .imem_wdata(wd[0]),
    .cpu_hold(hold[0]), .done(dn[0]), .err(er[0]), .count(cnt_a)
  );

  instr_encoder #(.IMEM_DEPTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start),
    .req_valid(req_valid), .req_ready(rdy[1]),
    .req_op(req_op), .req_rd(req_rd), .req_rs1(req_rs1),
    .req_rs2(req_rs2), .req_imm(req_imm), .req_last(req_last),
    .imem_we(we[1]), .imem_addr(addr[1]), .imem_wdata(wd[1]),
    .cpu_hold(hold[1]), .done(dn[1]), .err(er[1]), .count(cnt_b)
  );

  // ---------------- model ----------------
  function automatic logic [31:0] enc(input int op, input int rd,
                                      input int rs1, input int rs2,
                                      input int imm);
    int unsigned w;
    w = 0;
    case (op)
      0: w = (rs2 << 20) | (rs1 << 15) | (rd << 7) | 'h33;
      1: w = (32 << 25) | (rs2 << 20) | (rs1 << 15) | (rd << 7) | 'h33;
      2: w = ((imm & 'hFFF) << 20) | (rs1 << 15) | (rd << 7) | 'h13;
      3: w = ((imm & 'hFFF) << 20) | (rs1 << 15) | (2 << 12)
             | (rd << 7) | 'h03;
      4: w = (((imm >>> 5) & 'h7F) << 25) | (rs2 << 20) | (rs1 << 15)
             | (2 << 12) | ((imm & 'h1F) << 7) | 'h23;
      5: w = (((imm >>> 12) & 1) << 31) | (((imm >>> 5) & 'h3F) << 25)
             | (rs2 << 20) | (rs1 << 15) | (((imm >>> 1) & 'hF) << 8)
             | (((imm >>> 11) & 1) << 7) | 'h63;
      default: w = 0;
    endcase
    return w;
  endfunction

  function automatic bit bad(input int op, input int imm);
    if (op > 5) return 1'b1;
    if (op >= 2 && op <= 4 && (imm < -2048 || imm > 2047)) return 1'b1;
    if (op == 5 && (imm % 2) != 0) return 1'b1;
    return 1'b0;
  endfunction

  int          m_st  [2];   // 0 idle, 1 loading, 2 finished
  int          m_cnt [2];
  bit          m_err [2];
  bit          m_we  [2];
  logic [31:0] m_addr[2];
  logic [31:0] m_wd  [2];
  int          nwr   [2];
  int          depth [2] = '{256, 4};

  always @(posedge clk or negedge rst_n) begin
    int imv;
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_st[i] = 0; m_cnt[i] = 0; m_err[i] = 0; m_we[i] = 0;
        m_addr[i] = 0; m_wd[i] = 0;
      end
    end else begin
      imv = $signed(req_imm);
      for (int i = 0; i < 2; i++) begin
        m_we[i] = 0;
        if (m_st[i] == 1) begin
          if (req_valid) begin
            if (bad(req_op, imv)) m_err[i] = 1;
            else begin
              m_we[i] = 1;
              m_addr[i] = 4 * m_cnt[i];
              m_wd[i] = enc(req_op, req_rd, req_rs1, req_rs2, imv);
              m_cnt[i]++;
            end
            if (req_last || m_cnt[i] == depth[i]) m_st[i] = 2;
          end
        end else if (start) begin
          m_st[i] = 1; m_cnt[i] = 0; m_err[i] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [8:0] c;
    for (int i = 0; i < 2; i++) begin
      c = (i == 0) ? cnt_a : {6'd0, cnt_b};
      if (we[i]) nwr[i]++;
      tests++;
      if (rdy[i] !== (m_st[i] == 1) || hold[i] !== (m_st[i] == 1) ||
          dn[i] !== (m_st[i] == 2) || er[i] !== m_err[i] ||
          we[i] !== m_we[i] || addr[i] !== m_addr[i] ||
          wd[i] !== m_wd[i] || c !== 9'(m_cnt[i])) begin
        fails++;
        $display("FAIL cycle_cmp inst%0d t=%0t: got rdy%b hold%b done%b err%b we%b addr%h wd%h cnt%0d; want st%0d err%b we%b addr%h wd%h cnt%0d",
                 i, $time, rdy[i], hold[i], dn[i], er[i], we[i], addr[i],
                 wd[i], c, m_st[i], m_err[i], m_we[i], m_addr[i], m_wd[i],
                 m_cnt[i]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic send(input int op, input int rd, input int rs1,
                      input int rs2, input int imm, input bit last);
    bit acc;
    int n;
    req_valid = 1'b1;
    req_op = 3'(op); req_rd = 5'(rd); req_rs1 = 5'(rs1);
    req_rs2 = 5'(rs2); req_imm = 13'(imm); req_last = last;
    n = 0;
    do begin
      acc = rdy[0];
      cyc();
      n++;
    end while (!acc && n < 20);
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_last = 1'b0;
  endtask

  task automatic chk_zero(input string nm);
    for (int i = 0; i < 2; i++) begin
      chk(nm, {rdy[i], we[i], hold[i], dn[i], er[i]}, 32'd0);
      chk(nm, addr[i] | wd[i], 32'd0);
    end
    chk(nm, {23'd0, cnt_a} | {29'd0, cnt_b}, 32'd0);
  endtask

  initial begin
    int w0;
    // pin the model encoder against hand-computed words
    chk("enc_add",  enc(0, 3, 1, 2, 0),  32'h002081B3);
    chk("enc_sub",  enc(1, 3, 1, 2, 0),  32'h402081B3);
    chk("enc_addi", enc(2, 1, 0, 0, 5),  32'h00500093);
    chk("enc_lw",   enc(3, 5, 2, 0, 8),  32'h00812283);
    chk("enc_sw",   enc(4, 0, 2, 5, 8),  32'h00512423);
    chk("enc_beq",  enc(5, 0, 1, 2, -4), 32'hFE208EE3);

    #2;
    chk_zero("reset_state");
    cyc();
    rst_n = 1'b1;
    cyc();

    // session 1: single ADD
    do_start();
    chk("hold_in_load", 32'(hold[0]), 32'd1);
    send(0, 3, 1, 2, 0, 1);
    idle();
    chk("add_we", 32'(we[0]), 32'd1);
    chk("add_addr", addr[0], 32'h0);
    chk("add_wd", wd[0], 32'h002081B3);
    chk("add_cnt", 32'(cnt_a), 32'd1);
    chk("add_done", 32'(dn[0]), 32'd1);
    cyc();
    chk("we_pulse", 32'(we[0]), 32'd0);
    chk("wd_hold", wd[0], 32'h002081B3);

    // session 2: back-to-back
    do_start();
    send(1, 3, 1, 2, 0, 0);
    chk("sub_wd", wd[0], 32'h402081B3);
    send(2, 1, 0, 0, 5, 0);
    chk("addi_wd", wd[0], 32'h00500093);
    chk("addi_addr", addr[0], 32'h4);
    send(3, 5, 2, 0, 8, 1);
    idle();
    chk("lw_wd", wd[0], 32'h00812283);
    chk("lw_addr", addr[0], 32'h8);
    cyc();

    // session 3: SW then BEQ last
    do_start();
    send(4, 0, 2, 5, 8, 0);
    chk("sw_wd", wd[0], 32'h00512423);
    send(5, 0, 1, 2, -4, 1);
    idle();
    chk("beq_wd", wd[0], 32'hFE208EE3);
    chk("beq_done", 32'(dn[0]), 32'd1);
    chk("beq_hold", 32'(hold[0]), 32'd0);
    chk("beq_ready", 32'(rdy[0]), 32'd0);
    chk("beq_cnt", 32'(cnt_a), 32'd2);
    cyc();

    // session 4: illegal requests
    do_start();
    send(6, 1, 1, 1, 0, 0);
    chk("op6_we", 32'(we[0]), 32'd0);
    chk("op6_err", 32'(er[0]), 32'd1);
    chk("op6_cnt", 32'(cnt_a), 32'd0);
    send(2, 1, 0, 0, 2048, 0);
    chk("imm2048_we", 32'(we[0]), 32'd0);
    chk("imm2048_cnt", 32'(cnt_a), 32'd0);
    send(5, 0, 1, 2, 3, 0);
    chk("beq_odd_we", 32'(we[0]), 32'd0);
    send(2, 1, 0, 0, -2048, 0);
    chk("imm_min_we", 32'(we[0]), 32'd1);
    chk("imm_min_wd", wd[0], 32'h80000093);
    send(0, 3, 1, 2, 0, 1);
    idle();
    chk("post_ill_addr", addr[0], 32'h4);
    chk("post_ill_err", 32'(er[0]), 32'd1);
    cyc();
    do_start();
    chk("err_cleared", 32'(er[0]), 32'd0);

    // session 5: depth-4 fill (both instances in LOAD)
    w0 = nwr[1];
    for (int k = 0; k < 5; k++) send(0, k + 1, 1, 2, 0, 0);
    idle();
    cyc();
    chk("full_writes", 32'(nwr[1] - w0), 32'd4);
    chk("full_cnt", 32'(cnt_b), 32'd4);
    chk("full_done", 32'(dn[1]), 32'd1);
    chk("full_last_addr", addr[1], 32'hC);
    chk("deep_cnt", 32'(cnt_a), 32'd5);

    // async reset mid-cycle, then mid-session after 2 writes
    #2 rst_n = 1'b0;
    #1 chk_zero("async_rst_a");
    cyc();
    rst_n = 1'b1;
    cyc();
    do_start();
    send(0, 3, 1, 2, 0, 0);
    send(1, 3, 1, 2, 0, 0);
    idle();
    #2 rst_n = 1'b0;
    #1 chk_zero("async_rst_b");
    cyc();
    rst_n = 1'b1;
    cyc();
    do_start();
    send(2, 1, 0, 0, 5, 1);
    idle();
    chk("restart_addr", addr[0], 32'h0);
    chk("restart_wd", wd[0], 32'h00500093);
    chk("restart_cnt", 32'(cnt_a), 32'd1);
    cyc();
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
